// File: rtl/hlu_if.sv
`default_nettype none
// ============================================================================
// Module      : hlu_if
// Description : Command/result bundle between the E stage and the HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hlu_if;
  logic [3:0]  hluControl;
  logic        hluUnsigned;
  logic        hluWrite;
  logic        hluDst;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        start;
  logic        busy;
  logic [31:0] hluOut;

  modport master (
    output hluControl, hluUnsigned, hluWrite, hluDst, srcA, srcB,
    input  start, busy, hluOut
  );

  modport slave (
    input  hluControl, hluUnsigned, hluWrite, hluDst, srcA, srcB,
    output start, busy, hluOut
  );
endinterface
`default_nettype wire

// File: rtl/hlu.sv
`default_nettype none
// ============================================================================
// Module      : hlu
// Description : Fixed-latency HI/LO unit executing mult/div and mthi/mtlo.
// Revision    : 1.0 - initial release
// ============================================================================
module hlu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic clk,
  input  wire logic reset,
  hlu_if.slave      bus
);

  localparam int c_cnt_max = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  localparam logic [3:0] c_op_mult = 4'b0001;
  localparam logic [3:0] c_op_div  = 4'b0010;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_phi;
  logic [31:0]        r_plo;
  logic               r_div_zero;

  logic               w_is_mult;
  logic               w_is_div;
  logic               w_start;
  logic               w_commit;
  logic               w_last;

  // ---------------- result datapath ----------------
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_divisor;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_b_zero;

  assign w_is_mult = (bus.hluControl == c_op_mult);
  assign w_is_div  = (bus.hluControl == c_op_div);

  assign w_a_ext = bus.hluUnsigned ? {32'b0, bus.srcA} : {{32{bus.srcA[31]}}, bus.srcA};
  assign w_b_ext = bus.hluUnsigned ? {32'b0, bus.srcB} : {{32{bus.srcB[31]}}, bus.srcB};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide works on magnitudes; 0x80000000 is its own magnitude, which
  // makes the 0x80000000 / -1 case fall out as 0x80000000 rem 0.
  assign w_neg_a   = ~bus.hluUnsigned & bus.srcA[31];
  assign w_neg_b   = ~bus.hluUnsigned & bus.srcB[31];
  assign w_mag_a   = w_neg_a ? (32'd0 - bus.srcA) : bus.srcA;
  assign w_mag_b   = w_neg_b ? (32'd0 - bus.srcB) : bus.srcB;
  assign w_b_zero  = (bus.srcB == 32'd0);
  assign w_divisor = w_b_zero ? 32'd1 : w_mag_b;
  assign w_q_mag   = w_mag_a / w_divisor;
  assign w_r_mag   = w_mag_a % w_divisor;
  assign w_quot    = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem     = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

  assign w_last = (r_cnt == c_cnt_w'(1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_is_mult || w_is_div) w_state_nxt = c_st_run;
      c_st_run:  if (w_last)                w_state_nxt = c_st_idle;
      default:                              w_state_nxt = c_st_idle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_start  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      c_st_idle: w_start  = ~reset & (w_is_mult | w_is_div);
      c_st_run:  w_commit = w_last & ~r_div_zero;
      default: begin
        w_start  = 1'b0;
        w_commit = 1'b0;
      end
    endcase
  end

  // ---------------- HI/LO, pending result, counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_phi      <= 32'd0;
      r_plo      <= 32'd0;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
    end else if (w_start) begin
      if (w_is_mult) begin
        r_phi      <= w_prod[63:32];
        r_plo      <= w_prod[31:0];
        r_cnt      <= c_cnt_w'(MULT_CYCLES);
        r_div_zero <= 1'b0;
      end else begin
        r_phi      <= w_rem;
        r_plo      <= w_quot;
        r_cnt      <= c_cnt_w'(DIV_CYCLES);
        r_div_zero <= w_b_zero;
      end
    end else if (r_state == c_st_run) begin
      r_cnt <= r_cnt - c_cnt_w'(1);
      if (w_commit) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (bus.hluWrite) begin
      if (bus.hluDst) r_hi <= bus.srcA;
      else            r_lo <= bus.srcA;
    end
  end

  assign bus.start  = w_start;
  assign bus.busy   = (r_state == c_st_run);
  assign bus.hluOut = bus.hluDst ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: doc/hlu.md
# hlu

Multi-cycle HI/LO unit for the P6 pipeline, in the E stage beside the ALU. It executes mult/multu/div/divu with fixed latencies, handles mthi/mtlo writes, and supplies HI or LO for mfhi/mflo. It drives `start`/`busy` so the hazard unit can stall HI/LO-class instructions in D while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1)

- `clk` in 1: clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `hluControl` in 4: E-stage command. 4'b0001 = mult, 4'b0010 = div, 4'b0000 = none. Other codes are treated as none.
- `hluUnsigned` in 1: 1 selects multu/divu
- `hluWrite` in 1: E-stage mthi/mtlo
- `hluDst` in 1: 1 = HI, 0 = LO. Selects the target for `hluWrite` and the source for `hluOut`.
- `srcA` in 32: forwarded rs value (dividend, multiplicand, mthi/mtlo data)
- `srcB` in 32: forwarded rt value (divisor, multiplier)
- `start` out 1: combinational, high when a mult/div command is accepted this cycle
- `busy` out 1: registered, high while an operation is in flight
- `hluOut` out 32: combinational, `hluDst ? HI : LO`

## Operation
- State: `HI`, `LO` (32b each), `cnt` (width clog2(max(MULT_CYCLES, DIV_CYCLES)+1)), pending result `pHI`/`pLO`, `busy`.
- FSM has two states:
  - IDLE (busy=0)
  - RUN (busy=1, cnt counts down)
- **Accept.** In IDLE, with `hluControl` = mult or div:
  - `start` = 1.
  - Compute the result from the current `srcA`/`srcB` and latch it into `pHI`/`pLO`.
  - Load `cnt` with the latency and go to RUN.
- **mult.** {pHI,pLO} = 64-bit product. Use signed×signed unless `hluUnsigned` = 1, then unsigned×unsigned.
- **div.** pLO = quotient, pHI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Unsigned otherwise.
  - 0x80000000 / 0xFFFFFFFF (signed): pLO = 0x80000000, pHI = 0.
  - Divide by zero: the operation still takes DIV_CYCLES. On completion HI/LO keep their previous values.
- **RUN.** `cnt` decrements every cycle. At the edge where `cnt` = 1:
  - Commit `pHI`→HI and `pLO`→LO (except divide by zero).
  - Set `busy` to 0 and return to IDLE.
- **mthi/mtlo.** In IDLE with `hluWrite` = 1, at the edge write `srcA` into HI (`hluDst` = 1) or LO (`hluDst` = 0).
- **Commands in RUN.** Any mult/div or `hluWrite` while in RUN is ignored and `start` stays 0. The hazard unit prevents this case; the bench flags it with an assertion.
- **Simultaneous commands.** If mult/div and `hluWrite` are asserted together, mult/div wins and the write is dropped. Decode never produces this combination.
- **Reads.** `hluOut` always reflects the committed HI/LO, never pending values. It is valid for mfhi/mflo only when `busy` = 0; the stall unit guarantees this.

## Timing
- Reset values: HI = 0, LO = 0, `busy` = 0, `cnt` = 0, `pHI`/`pLO` = 0, state IDLE. `start` is 0 during reset; `hluOut` = 0.
- Reset in RUN aborts the operation: nothing is committed and IDLE is entered on the next cycle.
- Command sampled in cycle T:
  - `start` = 1 in T.
  - `busy` = 1 in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO update at the end of T+N and are visible in T+N+1, when `busy` = 0.
- A new command is accepted in T+N+1, giving back-to-back throughput of one operation per N+1 cycles.
- mthi/mtlo sampled in T: the new value appears on `hluOut` in T+1.
- The stall unit stalls D-stage `cal_hl`/`read_hl`/`write_hl` instructions while `start | busy`.

## Test plan
- **mult signed:** srcA = 0xFFFFFFFE (−2), srcB = 3, mult.
  - `busy` is high for exactly 5 cycles.
  - Cycle 6 after the command: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - Repeat with multu: HI = 0x00000002, LO = 0xFFFFFFFA.
- **div signed:** −7 / 2.
  - `busy` is high for 10 cycles.
  - LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1).
  - Repeat with divu 7/2: LO = 3, HI = 1.
- **Divide by zero:** mthi 0x11, mtlo 0x22, then div by 0.
  - `busy` is high for 10 cycles.
  - HI/LO stay 0x11/0x22.
- **Overflow divide:** signed 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Busy lockout and read-old:** mult 3×4, then issue mthi 0x55 and a div in cycles T+2 and T+3.
  - Both commands are ignored and `start` stays 0.
  - `hluOut` (`hluDst` = 0) shows the old LO until T+6, then 12.
- **Reset mid-operation:** reset asserted in T+3 of a div.
  - Next cycle: `busy` = 0, HI = LO = 0.
  - A mult issued immediately after completes normally.
